// File: rtl/petris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : petris_pkg
// Purpose  : Shared button indices, widths and the auto-repeat state type for
//            the petris input path.
// Revision : 1.0  initial release
// ============================================================================
package petris_pkg;

    localparam int NUM_BUTTONS = 5;

    localparam int RIGHT  = 0;
    localparam int LEFT   = 1;
    localparam int DOWN   = 2;
    localparam int ROTATE = 3;
    localparam int START  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Two-flop synchroniser, stable-count debounce and a one-cycle
//            pulse on each debounced rising edge.
// Revision : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    // The count only runs while the synchronised input disagrees with the
    // current level; any agreement (a bounce back) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/input_controller.sv
`default_nettype none
// ============================================================================
// Module   : input_controller
// Purpose  : Conditions the raw buttons and vsync into a per-frame operation
//            vector and frame counter. Define INPUT_AUTOREPEAT_EN to build the
//            DAS/ARR auto-repeat for RIGHT, LEFT and DOWN.
// Revision : 1.0  initial release
// ============================================================================
module input_controller
    import petris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DAS_FRAMES      = 10,
    parameter int ARR_FRAMES      = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   vsync,
    output logic [NUM_BUTTONS-1:0] operation,
    output logic [10:0]            framenumber
);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_event;
    logic [NUM_BUTTONS-1:0] w_op_frame;
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [2:0]             r_vs_sync;
    logic                   r_fb;
    logic                   w_unused_level;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clock),
            .rst_n  (reset_n),
            .i_raw  (btn_raw[i]),
            .o_level(w_level[i]),
            .o_rise (w_rise[i])
        );
    end

    assign w_unused_level = ^w_level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_sync <= 3'b000;
            r_fb      <= 1'b0;
        end else begin
            r_vs_sync <= {r_vs_sync[1:0], vsync};
            r_fb      <= r_vs_sync[1] & ~r_vs_sync[2];
        end
    end

`ifdef INPUT_AUTOREPEAT_EN
    localparam int c_frame_w = $clog2(max_int(DAS_FRAMES, ARR_FRAMES) + 1);
    localparam logic [c_frame_w-1:0] c_das = c_frame_w'(DAS_FRAMES);
    localparam logic [c_frame_w-1:0] c_arr = c_frame_w'(ARR_FRAMES);

    for (genvar i = RIGHT; i <= DOWN; i++) begin : g_repeat
        repeat_state_t        r_state;
        repeat_state_t        w_state_nxt;
        logic [c_frame_w-1:0] r_cnt;
        logic [c_frame_w-1:0] w_cnt_nxt;
        logic [c_frame_w-1:0] w_cnt_inc;
        logic [c_frame_w-1:0] w_limit;
        logic                 w_fire;

        assign w_cnt_inc = r_cnt + c_frame_w'(1);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // DELAY and REPEAT differ only in how many frame boundaries they wait.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_fire      = 1'b0;
            w_limit     = (r_state == DELAY) ? c_das : c_arr;
            case (r_state)
                IDLE: begin
                    if (w_rise[i]) begin
                        w_fire      = 1'b1;
                        w_state_nxt = DELAY;
                        w_cnt_nxt   = '0;
                    end
                end
                DELAY, REPEAT: begin
                    if (!w_level[i]) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_fb) begin
                        if (w_cnt_inc >= w_limit) begin
                            w_fire      = 1'b1;
                            w_state_nxt = REPEAT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_event[i] = w_fire;
    end

    assign w_event[ROTATE] = w_rise[ROTATE];
    assign w_event[START]  = w_rise[START];
`else
    localparam int c_unused_cfg = DAS_FRAMES + ARR_FRAMES;

    assign w_event = w_rise;
`endif

    // Opposing moves cancel for the frame they are both pending in.
    always_comb begin
        w_op_frame = r_pending;
        if (r_pending[RIGHT] && r_pending[LEFT]) begin
            w_op_frame[RIGHT] = 1'b0;
            w_op_frame[LEFT]  = 1'b0;
        end
    end

    // An event coinciding with the frame boundary seeds the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending   <= '0;
            operation   <= '0;
            framenumber <= '0;
        end else if (r_fb) begin
            operation   <= w_op_frame;
            r_pending   <= w_event;
            framenumber <= framenumber + 11'd1;
        end else begin
            r_pending <= r_pending | w_event;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_controller
// Purpose  : Self-checking bench for input_controller: directed frame table,
//            bounce/reset sequences, randomized frames against a frame-level
//            reference model, and framenumber wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_input_controller;
    import petris_pkg::*;

    localparam int c_deb = 4;
    localparam int c_das = 3;
    localparam int c_arr = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  btn_raw;
    logic        vsync;
    logic [4:0]  operation;
    logic [10:0] framenumber;

    input_controller #(
        .DEBOUNCE_CYCLES(c_deb),
        .DAS_FRAMES     (c_das),
        .ARR_FRAMES     (c_arr)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .vsync      (vsync),
        .operation  (operation),
        .framenumber(framenumber)
    );

    always #5 clock = ~clock;

    // Free-running vsync: high for the first half of each period.
    int vs_period = 40;
    int phase     = 0;
    initial begin
        vsync = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            phase = (phase + 1 >= vs_period) ? 0 : phase + 1;
            vsync = (phase < vs_period / 2);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_phase(input int p);
        @(negedge clock);
        while (phase != p) @(negedge clock);
    endtask

    // ---------------- frame-level reference model ----------------
    logic [4:0]  m_lvl;
    logic [4:0]  m_pend;
    int          m_run [3];
    logic [10:0] exp_fn;

    task automatic model_reset();
        m_lvl  = '0;
        m_pend = '0;
        for (int b = 0; b < 3; b++) m_run[b] = 0;
        exp_fn = '0;
    endtask

    // Frame boundary: hand out what is pending, then credit held moves.
    task automatic model_fb(output logic [4:0] op);
        op = m_pend;
        if (op[RIGHT] && op[LEFT]) op[1:0] = 2'b00;
        m_pend = '0;
`ifdef INPUT_AUTOREPEAT_EN
        for (int b = 0; b < 3; b++) begin
            if (m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] >= c_das && (m_run[b] - c_das) % c_arr == 0) m_pend[b] = 1'b1;
            end
        end
`endif
    endtask

    task automatic model_apply(input logic [4:0] lvl);
        for (int b = 0; b < 5; b++) begin
            if (lvl[b] && !m_lvl[b]) begin
                m_pend[b] = 1'b1;
                if (b < 3) m_run[b] = 0;
            end
        end
        m_lvl = lvl;
    endtask

    task automatic sample_frame();
        logic [4:0] e;
        model_fb(e);
        exp_fn = exp_fn + 11'd1;
        wait_phase(8);
        check("operation", {6'd0, operation}, {6'd0, e});
        check("framenumber", framenumber, exp_fn);
    endtask

    task automatic run_frame(input logic [4:0] lvl);
        sample_frame();
        wait_phase(10);
        btn_raw = lvl;
        model_apply(lvl);
    endtask

    task automatic do_reset();
        wait_phase(20);
        reset_n = 1'b0;
        #1;
        check("rst_operation", {6'd0, operation}, 11'd0);
        check("rst_framenumber", framenumber, 11'd0);
        wait_phase(22);
        reset_n = 1'b1;
        model_reset();
        model_apply(btn_raw);
    endtask

    // ---------------- directed frame table ----------------
    typedef struct packed {
        logic [4:0] btn;
        logic [4:0] exp;
    } vec_t;

    localparam int c_nt = 27;
`ifdef INPUT_AUTOREPEAT_EN
    localparam logic [4:0] c_rep = 5'b00100;
`else
    localparam logic [4:0] c_rep = 5'b00000;
`endif

    vec_t tbl [c_nt];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{5'b01000, 5'b00000};
        tbl[1]  = '{5'b01000, 5'b01000};
        tbl[2]  = '{5'b01000, 5'b00000};
        tbl[3]  = '{5'b01000, 5'b00000};
        tbl[4]  = '{5'b00000, 5'b00000};
        tbl[5]  = '{5'b00000, 5'b00000};
        tbl[6]  = '{5'b00100, 5'b00000};
        tbl[7]  = '{5'b00100, 5'b00100};
        tbl[8]  = '{5'b00100, 5'b00000};
        tbl[9]  = '{5'b00100, 5'b00000};
        tbl[10] = '{5'b00100, c_rep};
        tbl[11] = '{5'b00100, 5'b00000};
        tbl[12] = '{5'b00000, c_rep};
        tbl[13] = '{5'b00000, 5'b00000};
        tbl[14] = '{5'b00011, 5'b00000};
        tbl[15] = '{5'b00011, 5'b00000};
        tbl[16] = '{5'b00011, 5'b00000};
        tbl[17] = '{5'b00011, 5'b00000};
        tbl[18] = '{5'b00011, 5'b00000};
        tbl[19] = '{5'b00011, 5'b00000};
        tbl[20] = '{5'b00011, 5'b00000};
        tbl[21] = '{5'b00000, 5'b00000};
        tbl[22] = '{5'b00010, 5'b00000};
        tbl[23] = '{5'b00000, 5'b00010};
        tbl[24] = '{5'b10000, 5'b00000};
        tbl[25] = '{5'b00000, 5'b10000};
        tbl[26] = '{5'b00000, 5'b00000};

        reset_n = 1'b0;
        btn_raw = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("por_operation", {6'd0, operation}, 11'd0);
        check("por_framenumber", framenumber, 11'd0);
        wait_phase(22);
        reset_n = 1'b1;

        for (int k = 0; k < c_nt; k++) begin
            exp_fn = exp_fn + 11'd1;
            wait_phase(8);
            check($sformatf("tbl%0d_operation", k), {6'd0, operation}, {6'd0, tbl[k].exp});
            check($sformatf("tbl%0d_framenumber", k), framenumber, exp_fn);
            wait_phase(10);
            btn_raw = tbl[k].btn;
        end

        // Bounce on RIGHT straddling a frame boundary: the event must only
        // count from the point the input finally settles.
        do_reset();
        run_frame(5'b00000);
        sample_frame();
        wait_phase(32); btn_raw[RIGHT] = 1'b1;
        wait_phase(34); btn_raw[RIGHT] = 1'b0;
        wait_phase(36); btn_raw[RIGHT] = 1'b1;
        wait_phase(38); btn_raw[RIGHT] = 1'b0;
        wait_phase(0);  btn_raw[RIGHT] = 1'b1;
        sample_frame();
        model_apply(5'b00001);
        run_frame(5'b00000);
        run_frame(5'b00000);
        run_frame(5'b00000);

        // Reset while DOWN is in its repeat phase with an event pending.
        run_frame(5'b00100);
        repeat (3) run_frame(5'b00100);
        run_frame(5'b01100);
        sample_frame();
        wait_phase(10);
        btn_raw = 5'b00100;
        model_apply(5'b00100);
        do_reset();
        repeat (7) run_frame(5'b00100);
        run_frame(5'b00000);
        run_frame(5'b00000);

        // Randomized frames against the reference model.
        for (int f = 0; f < 120; f++) begin
            logic [4:0] lvl;
            lvl = btn_raw ^ (5'($urandom) & 5'($urandom));
            run_frame(lvl);
        end
        run_frame(5'b00000);
        run_frame(5'b00000);

        // framenumber wrap with a short vsync period.
        do_reset();
        vs_period = 8;
        for (int n = 1; n <= 2050; n++) begin
            wait_phase(0);
            wait_phase(6);
            if (n == 1 || n >= 2047)
                check($sformatf("wrap_fn_%0d", n), framenumber, 11'(n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
